// File: rtl/frame_buf_scheduler_if.sv
// frame_buf_scheduler_if
// Handshake bundle between a frame writer / frame reader pair and the
// triple-buffer scheduler. The pulses come from the master side. The
// buffer base addresses and status flags come back from the slave side.
// The statistics counters exist only when FRAME_STATS_EN is defined.
interface frame_buf_scheduler_if;
    logic        wr_frame_done;
    logic        rd_frame_start;
    logic [31:0] wr_base_addr;
    logic [31:0] rd_base_addr;
    logic        rd_addr_reset;
    logic        rd_frame_valid;
`ifdef FRAME_STATS_EN
    logic [15:0] dropped_cnt;
    logic [15:0] repeated_cnt;
`endif

    // Side that issues frame events and consumes buffer addresses.
    modport master (
        output wr_frame_done,
        output rd_frame_start,
        input  wr_base_addr,
        input  rd_base_addr,
        input  rd_addr_reset,
`ifdef FRAME_STATS_EN
        input  dropped_cnt,
        input  repeated_cnt,
`endif
        input  rd_frame_valid
    );

    // Scheduler side.
    modport slave (
        input  wr_frame_done,
        input  rd_frame_start,
        output wr_base_addr,
        output rd_base_addr,
        output rd_addr_reset,
`ifdef FRAME_STATS_EN
        output dropped_cnt,
        output repeated_cnt,
`endif
        output rd_frame_valid
    );
endinterface

// File: rtl/frame_buf_scheduler.sv
// frame_buf_scheduler
// Triple-buffer frame scheduler. It rotates three DDR frame buffers between
// a writer, a reader and a "ready" slot.
// - A completed write swaps the writer buffer with the ready slot.
// - A reader frame start takes the ready slot if it holds an unread frame.
//   Otherwise the reader repeats its current frame.
// The indices update one cycle after a pulse. The base addresses and
// rd_addr_reset follow one cycle later.
// Optional build macro: FRAME_STATS_EN adds the dropped_cnt and
// repeated_cnt saturating counters.
module frame_buf_scheduler #(
    parameter logic [31:0] FRAME_BASE_ADDR = 32'h0100_0000,
    parameter logic [31:0] FRAME_STRIDE    = 32'h0002_5800
) (
    input  logic                    clk_100Mhz,
    input  logic                    rst,
    frame_buf_scheduler_if.slave    bus
);

    typedef enum logic {
        EMPTY   = 1'b0,   // ready slot holds nothing unread
        PENDING = 1'b1    // ready slot holds a complete, undisplayed frame
    } state_t;

    state_t      state_q;
    logic [1:0]  wr_idx_q;
    logic [1:0]  rd_idx_q;
    logic [1:0]  rdy_idx_q;
    logic        rd_frame_valid_q;
    logic        rd_start_seen_q;   // delays rd_addr_reset to line up with the new address
    logic        rd_addr_reset_q;
    logic [31:0] wr_base_addr_q;
    logic [31:0] rd_base_addr_q;
    logic [31:0] wr_base_addr_d;
    logic [31:0] rd_base_addr_d;

    // Base address of every buffer. Entry 3 can never be selected because
    // the indices only take the values 0..2. It exists only to make the
    // table cover the full 2-bit index.
    logic [31:0] buf_addr [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_buf_addr
            assign buf_addr[gi] = FRAME_BASE_ADDR + FRAME_STRIDE * 32'(gi);
        end
    endgenerate

    // Buffer-rotation FSM. All three index moves are permutations, so the
    // indices stay pairwise distinct by construction.
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            state_q          <= EMPTY;
            wr_idx_q         <= 2'd0;
            rd_idx_q         <= 2'd1;
            rdy_idx_q        <= 2'd2;
            rd_frame_valid_q <= 1'b0;
            rd_start_seen_q  <= 1'b0;
        end else begin
            rd_start_seen_q <= bus.rd_frame_start;
            case ({bus.wr_frame_done, bus.rd_frame_start})
                2'b11: begin
                    // The fresh frame goes straight to the reader.
                    // Any older pending frame is dropped.
                    rd_idx_q         <= wr_idx_q;
                    wr_idx_q         <= rdy_idx_q;
                    rdy_idx_q        <= rd_idx_q;
                    state_q          <= EMPTY;
                    rd_frame_valid_q <= 1'b1;
                end
                2'b10: begin
                    wr_idx_q  <= rdy_idx_q;
                    rdy_idx_q <= wr_idx_q;
                    state_q   <= PENDING;
                end
                2'b01: begin
                    if (state_q == PENDING) begin
                        rd_idx_q         <= rdy_idx_q;
                        rdy_idx_q        <= rd_idx_q;
                        state_q          <= EMPTY;
                        rd_frame_valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address lookup from the current indices.
    always_comb begin
        wr_base_addr_d = buf_addr[wr_idx_q];
        rd_base_addr_d = buf_addr[rd_idx_q];
    end

    // Registered base addresses, and an offset-clear pulse that coincides
    // with the first cycle of the new reader address.
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            wr_base_addr_q  <= FRAME_BASE_ADDR;
            rd_base_addr_q  <= FRAME_BASE_ADDR + FRAME_STRIDE;
            rd_addr_reset_q <= 1'b0;
        end else begin
            wr_base_addr_q  <= wr_base_addr_d;
            rd_base_addr_q  <= rd_base_addr_d;
            rd_addr_reset_q <= rd_start_seen_q;
        end
    end

    assign bus.wr_base_addr   = wr_base_addr_q;
    assign bus.rd_base_addr   = rd_base_addr_q;
    assign bus.rd_addr_reset  = rd_addr_reset_q;
    assign bus.rd_frame_valid = rd_frame_valid_q;

`ifdef FRAME_STATS_EN
    logic        drop_evt;
    logic        repeat_evt;
    logic [15:0] dropped_cnt_q;
    logic [15:0] repeated_cnt_q;

    // A write overwrites the ready slot while it still holds an unread frame.
    assign drop_evt   = bus.wr_frame_done && (state_q == PENDING);
    // The reader starts a frame with nothing new available.
    assign repeat_evt = bus.rd_frame_start && !bus.wr_frame_done && (state_q == EMPTY);

    // Saturating statistics counters.
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            dropped_cnt_q  <= 16'd0;
            repeated_cnt_q <= 16'd0;
        end else begin
            if (drop_evt && dropped_cnt_q != 16'hFFFF)
                dropped_cnt_q <= dropped_cnt_q + 16'd1;
            if (repeat_evt && repeated_cnt_q != 16'hFFFF)
                repeated_cnt_q <= repeated_cnt_q + 16'd1;
        end
    end

    assign bus.dropped_cnt  = dropped_cnt_q;
    assign bus.repeated_cnt = repeated_cnt_q;
`endif

endmodule

// File: tb/tb_frame_buf_scheduler.sv
// tb_frame_buf_scheduler
// Directed bench for frame_buf_scheduler. Expected addresses are
// hand-computed from base 0x0100_0000 and stride 0x0002_5800:
// buffer 0 = 0x0100_0000, buffer 1 = 0x0102_5800, buffer 2 = 0x0104_B000.
// Counter checks are compiled only when FRAME_STATS_EN is defined.
module tb_frame_buf_scheduler;

    localparam logic [31:0] A0 = 32'h0100_0000;
    localparam logic [31:0] A1 = 32'h0102_5800;
    localparam logic [31:0] A2 = 32'h0104_B000;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   pulse_cnt;
    int   collisions;
    int   snap;

    frame_buf_scheduler_if bus ();

    frame_buf_scheduler #(
        .FRAME_BASE_ADDR(32'h0100_0000),
        .FRAME_STRIDE   (32'h0002_5800)
    ) dut (
        .clk_100Mhz(clk),
        .rst       (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rd_addr_reset pulses and watch for write/read address collisions.
    initial begin
        pulse_cnt  = 0;
        collisions = 0;
    end
    always @(posedge clk) if (bus.rd_addr_reset === 1'b1) pulse_cnt <= pulse_cnt + 1;
    always @(negedge clk) if (bus.wr_base_addr === bus.rd_base_addr) collisions <= collisions + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("check %s: got=%h ok", tag, got);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.wr_frame_done  = 1'b0;
        bus.rd_frame_start = 1'b0;
        wait_cycles(2);
        rst = 1'b0;
    endtask

    // One-cycle pulse on either or both inputs. The task returns at the
    // negedge after the sampling edge, when the indices have updated but
    // the addresses have not yet.
    task automatic pulse(input logic w, input logic r);
        @(negedge clk);
        bus.wr_frame_done  = w;
        bus.rd_frame_start = r;
        @(negedge clk);
        bus.wr_frame_done  = 1'b0;
        bus.rd_frame_start = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.wr_frame_done  = 1'b0;
        bus.rd_frame_start = 1'b0;

        // Reset state
        do_reset();
        @(negedge clk);
        check("reset_wr_addr", bus.wr_base_addr, A0);
        check("reset_rd_addr", bus.rd_base_addr, A1);
        check("reset_valid", 32'(bus.rd_frame_valid), 32'd0);
        check("reset_addr_rst", 32'(bus.rd_addr_reset), 32'd0);

        // Write done, then a read start 10 cycles later
        snap = pulse_cnt;
        pulse(1'b1, 1'b0);
        wait_cycles(10);
        check("wr1_wr_addr", bus.wr_base_addr, A2);
        check("wr1_rd_addr", bus.rd_base_addr, A1);
        check("wr1_valid", 32'(bus.rd_frame_valid), 32'd0);
        pulse(1'b0, 1'b1);
        check("rd_old_addr_hold", bus.rd_base_addr, A1);
        check("rd_addr_rst_early", 32'(bus.rd_addr_reset), 32'd0);
        @(negedge clk);
        check("rd_new_addr", bus.rd_base_addr, A0);
        check("rd_addr_rst_pulse", 32'(bus.rd_addr_reset), 32'd1);
        check("rd_wr_addr", bus.wr_base_addr, A2);
        check("rd_valid", 32'(bus.rd_frame_valid), 32'd1);
        wait_cycles(3);
        check("rd_one_pulse", 32'(pulse_cnt - snap), 32'd1);

        // Three writes, no reads
        do_reset();
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        @(negedge clk);
        check("w3_wr_addr", bus.wr_base_addr, A2);
        check("w3_rd_addr", bus.rd_base_addr, A1);
`ifdef FRAME_STATS_EN
        check("w3_dropped", 32'(bus.dropped_cnt), 32'd2);
        check("w3_repeated", 32'(bus.repeated_cnt), 32'd0);
`endif
        // The state must be PENDING, so the next read takes buffer 0.
        pulse(1'b0, 1'b1);
        @(negedge clk);
        check("w3_rd_takes", bus.rd_base_addr, A0);
        check("w3_valid", 32'(bus.rd_frame_valid), 32'd1);

        // Two reads, no writes
        do_reset();
        snap = pulse_cnt;
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        wait_cycles(2);
        check("r2_rd_addr", bus.rd_base_addr, A1);
        check("r2_pulses", 32'(pulse_cnt - snap), 32'd2);
        check("r2_valid", 32'(bus.rd_frame_valid), 32'd0);
`ifdef FRAME_STATS_EN
        check("r2_repeated", 32'(bus.repeated_cnt), 32'd2);
`endif

        // Both pulses together from reset
        do_reset();
        pulse(1'b1, 1'b1);
        @(negedge clk);
        check("both_rd_addr", bus.rd_base_addr, A0);
        check("both_wr_addr", bus.wr_base_addr, A2);
        check("both_valid", 32'(bus.rd_frame_valid), 32'd1);
`ifdef FRAME_STATS_EN
        check("both_dropped", 32'(bus.dropped_cnt), 32'd0);
`endif
        // The state is now EMPTY, so the next read repeats buffer 0.
        pulse(1'b0, 1'b1);
        @(negedge clk);
        check("both_then_rep", bus.rd_base_addr, A0);

        // Both pulses while PENDING: wr2 rd1 rdy0 -> rd2 wr0 rdy1
        do_reset();
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        @(negedge clk);
        check("bothp_rd_addr", bus.rd_base_addr, A2);
        check("bothp_wr_addr", bus.wr_base_addr, A0);
`ifdef FRAME_STATS_EN
        check("bothp_dropped", 32'(bus.dropped_cnt), 32'd1);
`endif

        // Reset while PENDING, together with a read start
        do_reset();
        pulse(1'b1, 1'b0);
        wait_cycles(2);
        snap = pulse_cnt;
        @(negedge clk);
        rst = 1'b1;
        bus.rd_frame_start = 1'b1;
        @(negedge clk);
        bus.rd_frame_start = 1'b0;
        check("rstp_wr_addr", bus.wr_base_addr, A0);
        check("rstp_rd_addr", bus.rd_base_addr, A1);
        check("rstp_valid", 32'(bus.rd_frame_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_cycles(3);
        check("rstp_no_pulse", 32'(pulse_cnt - snap), 32'd0);
`ifdef FRAME_STATS_EN
        check("rstp_dropped", 32'(bus.dropped_cnt), 32'd0);
`endif
        // The pending frame was discarded, so this read is a repeat.
        pulse(1'b0, 1'b1);
        @(negedge clk);
        check("rstp_read_rep", bus.rd_base_addr, A1);
        check("rstp_valid2", 32'(bus.rd_frame_valid), 32'd0);

        check("addr_collisions", 32'(collisions), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_buf_scheduler.md
FRAME_BUF_SCHEDULER -- requirements
Module: frame_buf_scheduler

Interface
REQ-001 Parameter FRAME_BASE_ADDR, 32'h0100_0000, DDR address of buffer 0.
REQ-002 Parameter FRAME_STRIDE, 32'h0002_5800, byte distance between buffers (320x240 x 2 B).
REQ-003 clk_100Mhz  input  1  AXI-domain clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_frame_done  input  1  one-cycle pulse: writer finished storing a complete frame.
REQ-006 rd_frame_start  input  1  one-cycle pulse, already synchronized to clk_100Mhz: reader about to fetch a new frame.
REQ-007 wr_base_addr  output  32  base address the writer uses for its current frame.
REQ-008 rd_base_addr  output  32  base address the AXI read path uses for its current frame.
REQ-009 rd_addr_reset  output  1  one-cycle pulse telling the read path to clear its address offset.
REQ-010 rd_frame_valid  output  1  high once the reader has been handed at least one complete frame.
REQ-011 dropped_cnt  output  16  frames overwritten before display (FRAME_STATS_EN only).
REQ-012 repeated_cnt  output  16  reader frames with no new frame available (FRAME_STATS_EN only).

Function
REQ-013 Block SHALL manage three buffers, indices 0..2, held in registers wr_idx, rd_idx, rdy_idx; the three SHALL always be pairwise distinct.
REQ-014 Pending-frame FSM SHALL have two states: EMPTY (rdy_idx holds no unread frame) and PENDING (rdy_idx holds a complete, undisplayed frame).
REQ-015 wr_frame_done alone: swap wr_idx and rdy_idx; go to PENDING; if already PENDING, the old pending frame is dropped.
REQ-016 rd_frame_start alone, PENDING: swap rd_idx and rdy_idx; go to EMPTY; set rd_frame_valid.
REQ-017 rd_frame_start alone, EMPTY: indices unchanged (reader repeats its frame); state stays EMPTY.
REQ-018 Both pulses in one cycle: rd_idx<=old wr_idx, wr_idx<=old rdy_idx, rdy_idx<=old rd_idx; go to EMPTY; set rd_frame_valid; the old pending frame, if any, is dropped.
REQ-019 wr_base_addr and rd_base_addr SHALL be registered FRAME_BASE_ADDR + idx*FRAME_STRIDE, computed in 32 bits, and valid one cycle after the index update (two cycles after the input pulse).
REQ-020 rd_addr_reset SHALL pulse one cycle for every rd_frame_start, in the same cycle the updated rd_base_addr first appears, including on repeats.
REQ-021 Pulses held high several cycles SHALL be treated as one event per cycle; callers guarantee single-cycle pulses.
REQ-022 rd_base_addr SHALL never equal wr_base_addr in any cycle.

Reset
REQ-023 On rst: wr_idx=0, rd_idx=1, rdy_idx=2, state EMPTY, rd_frame_valid=0, rd_addr_reset=0, counters=0.
REQ-024 After reset: wr_base_addr=32'h0100_0000, rd_base_addr=32'h0102_5800.
REQ-025 rst SHALL take priority over simultaneous pulses; reset mid-frame discards any pending frame.

Configuration
REQ-026 Macro FRAME_STATS_EN defined: dropped_cnt increments on each drop (REQ-015, REQ-018); repeated_cnt increments on each REQ-017 event; both saturate at 16'hFFFF.
REQ-027 FRAME_STATS_EN undefined: counters and ports SHALL be absent; scheduling behaviour identical.

Verification
REQ-028 Reset release -> wr_base_addr=0x0100_0000, rd_base_addr=0x0102_5800, rd_frame_valid=0.
REQ-029 wr_frame_done, then 10 cycles later rd_frame_start -> rd_base_addr=0x0100_0000, wr_base_addr=0x0104_B000, rd_frame_valid=1, one rd_addr_reset pulse.
REQ-030 Three wr_frame_done with no rd_frame_start -> dropped_cnt=2, state PENDING, wr and rd addresses always distinct.
REQ-031 Two rd_frame_start with no writes -> rd_base_addr stays 0x0102_5800, repeated_cnt=2, two rd_addr_reset pulses.
REQ-032 From reset, both pulses in the same cycle -> rd_base_addr=0x0100_0000, wr_base_addr=0x0104_B000, dropped_cnt=0.
REQ-033 rst asserted while PENDING, together with rd_frame_start -> all outputs return to REQ-023/REQ-024 values and no rd_addr_reset pulse occurs.
